// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the writeback port arbiter.
// The buffer entry layout and default sizing live here so that the FIFO and the arbiter agree on them.
package wb_arb_pkg;

  localparam int REG_IDX_W            = 5;
  localparam int DATA_W               = 32;
  localparam int WAIT_W               = 4;
  localparam int DEFAULT_DEPTH        = 2;
  localparam int DEFAULT_STARVE_LIMIT = 4;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic [DATA_W-1:0]    data;
  } wb_arb_entry_t;

endpackage

// File: rtl/wb_arb_fifo.sv
// Long-latency result buffer: circular FIFO with push, pop and rd-match invalidation.
// An invalidated entry keeps its slot and is still popped in order; only its valid bit drops.
module wb_arb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   i_srst,
  input  logic                   i_push,
  input  logic [REG_IDX_W-1:0]   i_push_rd,
  input  logic [DATA_W-1:0]      i_push_data,
  input  logic                   i_pop,
  input  logic                   i_inv,
  input  logic [REG_IDX_W-1:0]   i_inv_rd,
  output logic                   o_head_valid,
  output logic [REG_IDX_W-1:0]   o_head_rd,
  output logic [DATA_W-1:0]      o_head_data,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;
  wb_arb_entry_t    w_slots [DEPTH];
  wb_arb_entry_t    w_head;

  assign w_push = i_push && (r_count != FULL_CNT);
  assign w_pop  = i_pop && (r_count != '0);

  // The slot being written is always free, so a push never collides with an invalidate.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    wb_arb_entry_t r_slot;

    always_ff @(posedge clk) begin
      if (i_srst) begin
        r_slot.valid <= 1'b0;
      end else if (w_push && (r_wr_ptr == PTR_W'(gi))) begin
        r_slot <= '{valid: 1'b1, rd: i_push_rd, data: i_push_data};
      end else if (i_inv && (r_slot.rd == i_inv_rd)) begin
        r_slot.valid <= 1'b0;
      end
    end

    assign w_slots[gi] = r_slot;
  end

  always_ff @(posedge clk) begin
    if (i_srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign w_head       = w_slots[r_rd_ptr];
  assign o_head_valid = w_head.valid;
  assign o_head_rd    = w_head.rd;
  assign o_head_data  = w_head.data;
  assign o_count      = r_count;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the writeback stage and buffered long-latency results.
// Define WB_ARB_STARVE_EN to add the head wait counter and its STARVE_LIMIT stall term.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        RegWriteR,
  output logic [4:0]  RdR,
  output logic [31:0] WriteDataR,
  output logic        StallReq
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  if ((DEPTH < 2) || (DEPTH > 8) || ((DEPTH & (DEPTH - 1)) != 0) ||
      (STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_param
    $error("wb_port_arbiter: DEPTH or STARVE_LIMIT out of range");
  end

  logic                 w_pipe_wr;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_starve;
  logic                 w_stall_set;
  logic                 w_head_valid;
  logic [REG_IDX_W-1:0] w_head_rd;
  logic [DATA_W-1:0]    w_head_data;
  logic [CNT_W-1:0]     w_count;
  logic                 r_stall;

  assign w_pipe_wr = RegWriteW && (RdW != '0);
  assign w_empty   = (w_count == '0);
  assign w_full    = (w_count == FULL_CNT);
  assign lu_ready  = !w_full;
  // Results for x0 complete the handshake but are never stored.
  assign w_push    = lu_valid && lu_ready && (lu_rd != '0);

  wb_arb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk         (clk),
    .i_srst      (reset),
    .i_push      (w_push),
    .i_push_rd   (lu_rd),
    .i_push_data (lu_data),
    .i_pop       (w_pop),
    .i_inv       (w_pipe_wr),
    .i_inv_rd    (RdW),
    .o_head_valid(w_head_valid),
    .o_head_rd   (w_head_rd),
    .o_head_data (w_head_data),
    .o_count     (w_count)
  );

  // Pipeline writes always win; a dead head still takes a slot but writes nothing.
  always_comb begin
    RegWriteR  = 1'b0;
    RdR        = '0;
    WriteDataR = '0;
    w_pop      = 1'b0;
    if (w_pipe_wr) begin
      RegWriteR  = 1'b1;
      RdR        = RdW;
      WriteDataR = ResultW;
    end else if (!reset && !w_empty) begin
      w_pop = 1'b1;
      if (w_head_valid) begin
        RegWriteR  = 1'b1;
        RdR        = w_head_rd;
        WriteDataR = w_head_data;
      end
    end
  end

`ifdef WB_ARB_STARVE_EN
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_next;
  logic              w_blocked;

  assign w_blocked = w_pipe_wr && !w_empty;

  always_comb begin
    w_wait_next = r_wait;
    if (w_pop || w_empty) begin
      w_wait_next = '0;
    end else if (w_blocked && (r_wait != WAIT_MAX)) begin
      w_wait_next = r_wait + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_wait <= '0;
    else       r_wait <= w_wait_next;
  end

  // Stall rises on the same edge the wait count reaches the limit.
  assign w_starve = (w_wait_next == WAIT_MAX);
`else
  assign w_starve = 1'b0;
`endif

  assign w_stall_set = w_starve || (w_full && w_pipe_wr);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall <= 1'b0;
    end else if (w_pop) begin
      r_stall <= 1'b0;
    end else if (w_stall_set) begin
      r_stall <= 1'b1;
    end
  end

  assign StallReq = r_stall;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed and randomized checks of wb_port_arbiter against a queue-based reference model.
// Model follows WB_ARB_STARVE_EN the same way the design does.
module tb_wb_port_arbiter;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;
`ifdef WB_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        RegWriteR;
  logic [4:0]  RdR;
  logic [31:0] WriteDataR;
  logic        StallReq;

  wb_port_arbiter #(
    .DEPTH       (DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .RegWriteW (RegWriteW),
    .RdW       (RdW),
    .ResultW   (ResultW),
    .lu_valid  (lu_valid),
    .lu_rd     (lu_rd),
    .lu_data   (lu_data),
    .lu_ready  (lu_ready),
    .RegWriteR (RegWriteR),
    .RdR       (RdR),
    .WriteDataR(WriteDataR),
    .StallReq  (StallReq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          live;
  } ent_t;

  ent_t mq[$];
  bit   m_stall = 1'b0;
  int   m_wait  = 0;

  int n_checks = 0;
  int n_errors = 0;

  logic        obs_we, obs_ready, obs_stall;
  logic [4:0]  obs_rd;
  logic [31:0] obs_data;
  bit          saw_x9_stale = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs mid-cycle against the model, advance the model, step past the edge.
  task automatic cycle();
    bit          pipe, popped, accept;
    int          n0, wnext;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    @(negedge clk);
    pipe   = RegWriteW && (RdW != 5'd0);
    n0     = mq.size();
    e_we   = 1'b0;
    e_rd   = 5'd0;
    e_data = 32'd0;
    popped = 1'b0;
    if (pipe) begin
      e_we = 1'b1; e_rd = RdW; e_data = ResultW;
    end else if (!reset && n0 > 0) begin
      popped = 1'b1;
      if (mq[0].live) begin
        e_we = 1'b1; e_rd = mq[0].rd; e_data = mq[0].data;
      end
    end
    obs_we = RegWriteR; obs_rd = RdR; obs_data = WriteDataR;
    obs_ready = lu_ready; obs_stall = StallReq;
    if (RegWriteR === 1'b1 && RdR === 5'd9 && WriteDataR === 32'h11) saw_x9_stale = 1'b1;
    chk("RegWriteR", {31'd0, RegWriteR}, {31'd0, e_we});
    chk("RdR", {27'd0, RdR}, {27'd0, e_rd});
    chk("WriteDataR", WriteDataR, e_data);
    chk("lu_ready", {31'd0, lu_ready}, {31'd0, (n0 < DEPTH)});
    chk("StallReq", {31'd0, StallReq}, {31'd0, m_stall});
    if (reset) begin
      mq.delete();
      m_stall = 1'b0;
      m_wait  = 0;
    end else begin
      accept = lu_valid && (n0 < DEPTH);
      if (pipe) begin
        foreach (mq[i]) if (mq[i].rd == RdW) mq[i].live = 1'b0;
      end
      if (popped || n0 == 0)   wnext = 0;
      else if (pipe)           wnext = (m_wait + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_wait + 1;
      else                     wnext = m_wait;
      if (popped) m_stall = 1'b0;
      else if ((n0 == DEPTH && pipe) || (STARVE_EN && wnext == STARVE_LIMIT)) m_stall = 1'b1;
      m_wait = wnext;
      if (popped) void'(mq.pop_front());
      if (accept && lu_rd != 5'd0) mq.push_back('{rd: lu_rd, data: lu_data, live: 1'b1});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_pipe(input logic we, input logic [4:0] rd, input logic [31:0] d);
    RegWriteW = we; RdW = rd; ResultW = d;
  endtask

  task automatic set_lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    lu_valid = v; lu_rd = rd; lu_data = d;
  endtask

  initial begin
    reset = 1'b1;
    set_pipe(1'b0, 5'd0, 32'd0);
    set_lu(1'b0, 5'd0, 32'd0);
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    chk("reset_ready", {31'd0, obs_ready}, 32'd1);
    chk("reset_stall", {31'd0, obs_stall}, 32'd0);
    chk("reset_we", {31'd0, obs_we}, 32'd0);

    // Idle pipeline, one long-latency result.
    set_lu(1'b1, 5'd5, 32'hDEADBEEF);
    cycle();
    set_lu(1'b0, 5'd0, 32'd0);
    cycle();
    chk("lu_write_we", {31'd0, obs_we}, 32'd1);
    chk("lu_write_rd", {27'd0, obs_rd}, 32'd5);
    chk("lu_write_data", obs_data, 32'hDEADBEEF);
    cycle();
    chk("lu_write_empty_after", {31'd0, obs_we}, 32'd0);

    // Blocked by pipeline writes until full, then drain in order.
    set_pipe(1'b1, 5'd7, 32'h700);
    set_lu(1'b1, 5'd3, 32'h33);
    cycle();
    set_lu(1'b1, 5'd4, 32'h44);
    cycle();
    set_lu(1'b0, 5'd0, 32'd0);
    cycle();
    chk("full_ready_low", {31'd0, obs_ready}, 32'd0);
    chk("full_stall_not_yet", {31'd0, obs_stall}, 32'd0);
    cycle();
    chk("full_blocked_stall", {31'd0, obs_stall}, 32'd1);
    set_pipe(1'b0, 5'd0, 32'd0);
    cycle();
    chk("drain_first_rd", {27'd0, obs_rd}, 32'd3);
    chk("drain_first_data", obs_data, 32'h33);
    cycle();
    chk("drain_second_rd", {27'd0, obs_rd}, 32'd4);
    chk("stall_cleared_after_pop", {31'd0, obs_stall}, 32'd0);
    cycle();

    // Pipeline write to the same rd kills the buffered value.
    set_pipe(1'b1, 5'd7, 32'h700);
    set_lu(1'b1, 5'd9, 32'h11);
    cycle();
    set_lu(1'b0, 5'd0, 32'd0);
    set_pipe(1'b1, 5'd9, 32'h22);
    cycle();
    chk("kill_pipe_data", obs_data, 32'h22);
    set_pipe(1'b0, 5'd0, 32'd0);
    cycle();
    chk("dead_pop_no_write", {31'd0, obs_we}, 32'd0);
    cycle();
    chk("x9_never_stale", {31'd0, saw_x9_stale}, 32'd0);

    // x0 result: handshake only.
    set_lu(1'b1, 5'd0, 32'hABCD);
    cycle();
    chk("x0_ready", {31'd0, obs_ready}, 32'd1);
    set_lu(1'b0, 5'd0, 32'd0);
    cycle();
    chk("x0_no_write", {31'd0, obs_we}, 32'd0);

    // Single entry blocked for several cycles.
    set_pipe(1'b1, 5'd7, 32'h701);
    set_lu(1'b1, 5'd12, 32'hC);
    cycle();
    set_lu(1'b0, 5'd0, 32'd0);
    for (int k = 1; k <= 4; k++) cycle();
    chk("starve_cycle4_stall", {31'd0, obs_stall}, 32'd0);
    cycle();
    chk("starve_cycle5_stall", {31'd0, obs_stall}, {31'd0, STARVE_EN});
    cycle();
    set_pipe(1'b0, 5'd0, 32'd0);
    cycle();
    chk("starve_drain_rd", {27'd0, obs_rd}, 32'd12);
    cycle();

    // Reset with a full buffer.
    set_pipe(1'b1, 5'd7, 32'h702);
    set_lu(1'b1, 5'd20, 32'h20);
    cycle();
    set_lu(1'b1, 5'd21, 32'h21);
    cycle();
    set_pipe(1'b0, 5'd0, 32'd0);
    set_lu(1'b1, 5'd22, 32'h22);
    reset = 1'b1;
    cycle();
    chk("reset_full_no_write", {31'd0, obs_we}, 32'd0);
    reset = 1'b0;
    set_lu(1'b0, 5'd0, 32'd0);
    cycle();
    chk("after_reset_ready", {31'd0, obs_ready}, 32'd1);
    chk("after_reset_stall", {31'd0, obs_stall}, 32'd0);
    chk("after_reset_we", {31'd0, obs_we}, 32'd0);

    // Handshake coinciding with reset on an empty buffer is discarded.
    reset = 1'b1;
    set_lu(1'b1, 5'd23, 32'h23);
    cycle();
    reset = 1'b0;
    set_lu(1'b0, 5'd0, 32'd0);
    cycle();
    chk("reset_handshake_dropped", {31'd0, obs_we}, 32'd0);

    for (int n = 0; n < 400; n++) begin
      reset = (($urandom % 100) == 0);
      set_pipe(($urandom % 100) < 45, 5'($urandom % 8), $urandom);
      set_lu(($urandom % 100) < 60, 5'($urandom % 8), $urandom);
      cycle();
    end
    reset = 1'b0;
    set_pipe(1'b0, 5'd0, 32'd0);
    set_lu(1'b0, 5'd0, 32'd0);
    for (int n = 0; n < 4; n++) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
